// File: rtl/mac_feeder.sv
// Operand buffer and sequencer that streams SZN {a,x} pairs into an external MAC,
// waits out the MAC latency, then captures the accumulated dot product.
module mac_feeder #(
  parameter int SZin = 7,
  parameter int SZN  = 5,
  parameter int LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [SZin:0]          wr_a,
  input  logic [SZin:0]          wr_x,
  output logic                   full,
  input  logic                   start,
  output logic                   busy,
  output logic [SZin:0]          ai,
  output logic [SZin:0]          xni,
  output logic                   acc_clr,
  input  logic [2*(SZin+1):0]    mac_res,
  output logic [2*(SZin+1):0]    result,
  output logic                   done
);

  localparam int OW = SZin + 1;
  localparam int RW = 2 * OW + 1;
  localparam int PW = $clog2(SZN + 1);
  localparam int AW = (SZN > 1) ? $clog2(SZN) : 1;
  localparam int CW = $clog2(SZN + LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          acc_clr_q, acc_clr_d;
  logic [OW-1:0] ai_q, ai_d;
  logic [OW-1:0] xni_q, xni_d;
  logic [RW-1:0] result_q, result_d;
  logic          wr_accept;

  logic [OW-1:0] mem_a [SZN];
  logic [OW-1:0] mem_x [SZN];

  // Only an idle, non-full buffer takes writes; everything else drops them.
  assign wr_accept = (state_q == S_IDLE) && !full_q && wr_en;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_a[ptr_q[AW-1:0]] <= wr_a;
      mem_x[ptr_q[AW-1:0]] <= wr_x;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      ai_q      <= '0;
      xni_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_clr_q <= acc_clr_d;
      ai_q      <= ai_d;
      xni_q     <= xni_d;
      result_q  <= result_d;
    end
  end

  // Next-state logic; cnt indexes pairs in RUN and counts latency in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && full_q) begin
          state_d = S_CLR;
        end else if (wr_accept) begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == CW'(SZN - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(LAT - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in the flops with the state.
  always_comb begin
    full_d    = (ptr_d == PW'(SZN));
    busy_d    = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_WAIT);
    done_d    = (state_d == S_DONE);
    acc_clr_d = (state_d == S_CLR);
    ai_d      = '0;
    xni_d     = '0;
    result_d  = result_q;
    if (state_d == S_RUN) begin
      ai_d  = mem_a[cnt_d[AW-1:0]];
      xni_d = mem_x[cnt_d[AW-1:0]];
    end
    if (state_d == S_DONE) begin
      result_d = mac_res;
    end
  end

  assign full    = full_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_clr = acc_clr_q;
  assign ai      = ai_q;
  assign xni     = xni_q;
  assign result  = result_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed plus randomized checks of mac_feeder against a queue-based dot-product
// model, driving a simple accumulate-per-edge MAC with 9-bit wrap.
module tb_mac_feeder;

  localparam int SZin = 3;
  localparam int SZN  = 5;
  localparam int LAT  = 1;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_a;
  logic [3:0] wr_x;
  logic       full;
  logic       start;
  logic       busy;
  logic [3:0] ai;
  logic [3:0] xni;
  logic       acc_clr;
  logic [8:0] mac_res;
  logic [8:0] result;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Expected buffer contents in write order
  logic [3:0] qa[$];
  logic [3:0] qx[$];

  mac_feeder #(.SZin(SZin), .SZN(SZN), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_a    (wr_a),
    .wr_x    (wr_x),
    .full    (full),
    .start   (start),
    .busy    (busy),
    .ai      (ai),
    .xni     (xni),
    .acc_clr (acc_clr),
    .mac_res (mac_res),
    .result  (result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC: clear on acc_clr, otherwise accumulate ai*xni every edge.
  logic [8:0] prod;
  assign prod = 9'(ai) * 9'(xni);
  always @(posedge clk) begin
    if (acc_clr) mac_res <= 9'd0;
    else         mac_res <= mac_res + prod;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Write one pair while idle; the model keeps only the first SZN.
  task automatic wr(input logic [3:0] a, input logic [3:0] x);
    wr_en = 1'b1;
    wr_a  = a;
    wr_x  = x;
    step();
    wr_en = 1'b0;
    if (qa.size() < SZN) begin
      qa.push_back(a);
      qx.push_back(x);
    end
    $display("write a=%0d x=%0d -> full=%0d", a, x, full);
  endtask

  // One full run. inject: random start/wr_en pulses during RUN.
  // wr_with_start: a write presented on the start cycle. abort_k: reset at that RUN index.
  task automatic do_run(input bit inject, input bit wr_with_start, input int abort_k);
    int         s;
    logic [8:0] exp_res;
    s = 0;
    for (int i = 0; i < qa.size(); i++) s += int'(qa[i]) * int'(qx[i]);
    exp_res = 9'(s % 512);

    start = 1'b1;
    wr_en = wr_with_start;
    wr_a  = 4'($urandom);
    wr_x  = 4'($urandom);
    step();
    start = 1'b0;
    wr_en = 1'b0;
    chk("clr_acc_clr", acc_clr, 1);
    chk("clr_ai", ai, 0);
    chk("clr_xni", xni, 0);
    chk("clr_busy", busy, 1);

    for (int k = 0; k < SZN; k++) begin
      if (inject) begin
        start = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
        wr_a  = 4'($urandom);
        wr_x  = 4'($urandom);
      end
      step();
      start = 1'b0;
      wr_en = 1'b0;
      chk("run_ai", ai, qa[k]);
      chk("run_xni", xni, qx[k]);
      chk("run_acc_clr", acc_clr, 0);
      chk("run_busy", busy, 1);
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        chk("abort_ai", ai, 0);
        chk("abort_xni", xni, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_full", full, 0);
        chk("abort_result", result, 0);
        step();
        chk("abort_hold_done", done, 0);
        rst = 1'b1;
        step();
        chk("abort_after_done", done, 0);
        chk("abort_after_busy", busy, 0);
        qa.delete();
        qx.delete();
        $display("run aborted at k=%0d", k);
        return;
      end
    end

    for (int w = 0; w < LAT; w++) begin
      step();
      chk("wait_ai", ai, 0);
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
    end

    step();
    chk("done_pulse", done, 1);
    chk("done_result", result, exp_res);
    chk("done_busy", busy, 0);
    chk("done_ai", ai, 0);

    step();
    chk("post_done", done, 0);
    chk("post_full", full, 0);
    chk("post_result", result, exp_res);
    qa.delete();
    qx.delete();
    $display("run complete: result=%0d expected=%0d", result, exp_res);
  endtask

  initial begin
    rst   = 1'b0;
    wr_en = 1'b0;
    wr_a  = '0;
    wr_x  = '0;
    start = 1'b0;
    #1;
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_ai", ai, 0);
    chk("rst_xni", xni, 0);
    chk("rst_result", result, 0);
    step();
    rst = 1'b1;
    step();
    chk("rel_full", full, 0);
    chk("rel_busy", busy, 0);

    // a=1..5, x=2 -> 30
    for (int i = 1; i <= 5; i++) wr(4'(i), 4'd2);
    chk("load_full", full, 1);
    do_run(1'b0, 1'b0, -1);

    // Start with a partial buffer is ignored; sixth write dropped
    for (int i = 0; i < 3; i++) wr(4'($urandom), 4'($urandom));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("early_start_busy", busy, 0);
    chk("early_start_full", full, 0);
    for (int i = 0; i < 3; i++) wr(4'($urandom), 4'($urandom));
    chk("overflow_full", full, 1);
    do_run(1'b0, 1'b0, -1);

    // Inputs pulsed during a run have no effect, then a=x=1 -> 5
    for (int i = 0; i < 5; i++) wr(4'($urandom), 4'($urandom));
    do_run(1'b1, 1'b0, -1);
    for (int i = 0; i < 5; i++) wr(4'd1, 4'd1);
    do_run(1'b0, 1'b0, -1);

    // Write+start together: accepted write when not full, dropped write when full
    for (int i = 0; i < 4; i++) wr(4'($urandom), 4'($urandom));
    start = 1'b1;
    wr(4'd7, 4'd9);
    start = 1'b0;
    chk("wr_start_busy", busy, 0);
    chk("wr_start_full", full, 1);
    do_run(1'b0, 1'b1, -1);

    // Reset mid-run at k=2, then reload and run
    for (int i = 0; i < 5; i++) wr(4'($urandom), 4'($urandom));
    do_run(1'b0, 1'b0, 2);
    for (int i = 0; i < 5; i++) wr(4'($urandom), 4'($urandom));
    do_run(1'b0, 1'b0, -1);

    // Wrap case: 5 * 225 = 1125 -> 101
    for (int i = 0; i < 5; i++) wr(4'd15, 4'd15);
    do_run(1'b0, 1'b0, -1);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) wr(4'($urandom), 4'($urandom));
      do_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
